// File: rtl/vrf_read_pkg.sv
// Shared field widths and the request payload for the VRF read scheduler.
package vrf_read_pkg;

    localparam int unsigned VS_W  = 5;
    localparam int unsigned SRC_W = 2;
    localparam int unsigned OFF_W = 8;
    localparam int unsigned IDX_W = 3;

    typedef struct packed {
        logic [VS_W-1:0]  vs;
        logic [SRC_W-1:0] readSource;
        logic [OFF_W-1:0] offset;
        logic [IDX_W-1:0] instructionIndex;
    } vrf_read_req_t;

endpackage

// File: rtl/vrf_read_rr_arb.sv
// Combinational round-robin pick: the first valid index at or after ptr wins, wrapping.
module vrf_read_rr_arb #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         valid,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant_c,
    output logic [$clog2(NUM_REQ)-1:0] index_c,
    output logic                       found_c
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    logic [PTR_W:0] sum;

    always_comb begin
        grant_c = '0;
        index_c = '0;
        found_c = 1'b0;
        sum     = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(NUM_REQ)) begin
                sum = sum - (PTR_W+1)'(NUM_REQ);
            end
            if (!found_c && valid[sum[PTR_W-1:0]]) begin
                grant_c[sum[PTR_W-1:0]] = 1'b1;
                index_c                 = sum[PTR_W-1:0];
                found_c                 = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vrf_read_scheduler.sv
// Shares one VRF read port among NUM_REQ requesters with a registered one-entry request stage
// and a fixed-latency tag pipeline. Define VRF_READ_SCHED_PRIO0_EN to give requester 0 strict priority.
module vrf_read_scheduler
    import vrf_read_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [VS_W*NUM_REQ-1:0]     req_vs,
    input  logic [SRC_W*NUM_REQ-1:0]    req_readSource,
    input  logic [OFF_W*NUM_REQ-1:0]    req_offset,
    input  logic [IDX_W*NUM_REQ-1:0]    req_instructionIndex,
    output logic                        vrf_valid,
    input  logic                        vrf_ready,
    output logic [VS_W-1:0]             vrf_vs,
    output logic [SRC_W-1:0]            vrf_readSource,
    output logic [OFF_W-1:0]            vrf_offset,
    output logic [IDX_W-1:0]            vrf_instructionIndex,
    input  logic [DATA_WIDTH-1:0]       vrf_rdata,
    input  logic                        kill_valid,
    input  logic [IDX_W-1:0]            kill_index,
    output logic [NUM_REQ-1:0]          resp_valid,
    output logic [DATA_WIDTH-1:0]       resp_data
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]         state_q;
    logic [0:0]         state_d;
    vrf_read_req_t      entry_q;
    vrf_read_req_t      sel_req;
    logic [NUM_REQ-1:0] id_q;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   ptr_d;

    logic [NUM_REQ-1:0] arb_valid;
    logic [NUM_REQ-1:0] arb_grant;
    logic [PTR_W-1:0]   arb_index;
    logic               arb_found;
    logic [NUM_REQ-1:0] win;
    logic [PTR_W-1:0]   win_index;
    logic               win_found;

    logic fire;
    logic open;
    logic accept;
    logic kill_hit;
    logic upd_ptr;

    logic [READ_LATENCY-1:0] tag_valid;
    logic [NUM_REQ-1:0]      tag_id [READ_LATENCY];

    vrf_read_rr_arb #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .valid   (arb_valid),
        .ptr     (rr_ptr),
        .grant_c (arb_grant),
        .index_c (arb_index),
        .found_c (arb_found)
    );

`ifdef VRF_READ_SCHED_PRIO0_EN
    // Requester 0 bypasses the ring; the ring only ever sees requesters 1..NUM_REQ-1.
    assign arb_valid = {req_valid[NUM_REQ-1:1], 1'b0};

    always_comb begin
        win       = arb_grant;
        win_index = arb_index;
        win_found = arb_found;
        if (req_valid[0]) begin
            win       = NUM_REQ'(1);
            win_index = '0;
            win_found = 1'b1;
        end
    end

    assign upd_ptr = accept & (win_index != '0);
`else
    assign arb_valid = req_valid;
    assign win       = arb_grant;
    assign win_index = arb_index;
    assign win_found = arb_found;
    assign upd_ptr   = accept;
`endif

    assign vrf_valid = (state_q == ST_FULL);
    assign fire      = vrf_valid & vrf_ready;
    assign open      = (state_q == ST_EMPTY) | fire;
    assign accept    = win_found & open & ~reset;
    assign req_ready = accept ? win : '0;
    assign kill_hit  = kill_valid & vrf_valid & ~fire & (entry_q.instructionIndex == kill_index);

    assign ptr_d = (win_index == PTR_W'(NUM_REQ - 1)) ? '0 : win_index + PTR_W'(1);

    // Winner's payload, sliced out of the flat request buses.
    always_comb begin
        sel_req = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win_index == PTR_W'(i)) begin
                sel_req.vs               = req_vs[i*VS_W +: VS_W];
                sel_req.readSource       = req_readSource[i*SRC_W +: SRC_W];
                sel_req.offset           = req_offset[i*OFF_W +: OFF_W];
                sel_req.instructionIndex = req_instructionIndex[i*IDX_W +: IDX_W];
            end
        end
    end

    // Entry next state: a new accept refills; a fire or an un-fired kill empties.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = ST_FULL;
        end else if (fire || kill_hit) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            entry_q <= '0;
            id_q    <= '0;
            rr_ptr  <= '0;
        end else begin
            if (accept) begin
                entry_q <= sel_req;
                id_q    <= win;
            end
            if (upd_ptr) begin
                rr_ptr <= ptr_d;
            end
        end
    end

    assign vrf_vs               = entry_q.vs;
    assign vrf_readSource       = entry_q.readSource;
    assign vrf_offset           = entry_q.offset;
    assign vrf_instructionIndex = entry_q.instructionIndex;

    // Free-running tag shift register; the last stage lines up with vrf_rdata.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tag_valid <= '0;
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                tag_id[i] <= '0;
            end
        end else begin
            tag_valid[0] <= fire;
            tag_id[0]    <= id_q;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_id[i]    <= tag_id[i-1];
            end
        end
    end

    assign resp_valid = tag_valid[READ_LATENCY-1] ? tag_id[READ_LATENCY-1] : '0;
    assign resp_data  = vrf_rdata;

endmodule

// File: tb/tb_vrf_read_scheduler.sv
// Table-driven per-cycle bench for vrf_read_scheduler (default build or VRF_READ_SCHED_PRIO0_EN).
module tb_vrf_read_scheduler;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned DW      = 32;
    localparam int SEL_ZERO = 8;
    localparam int SEL_SKIP = 9;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic [NUM_REQ-1:0]   req_valid = '0;
    logic [NUM_REQ-1:0]   req_ready;
    logic [5*NUM_REQ-1:0] req_vs;
    logic [2*NUM_REQ-1:0] req_readSource;
    logic [8*NUM_REQ-1:0] req_offset;
    logic [3*NUM_REQ-1:0] req_instructionIndex;
    logic                 vrf_valid;
    logic                 vrf_ready = 1'b0;
    logic [4:0]           vrf_vs;
    logic [1:0]           vrf_readSource;
    logic [7:0]           vrf_offset;
    logic [2:0]           vrf_instructionIndex;
    logic [DW-1:0]        vrf_rdata = '0;
    logic                 kill_valid = 1'b0;
    logic [2:0]           kill_index = '0;
    logic [NUM_REQ-1:0]   resp_valid;
    logic [DW-1:0]        resp_data;

    vrf_read_scheduler #(
        .NUM_REQ      (NUM_REQ),
        .DATA_WIDTH   (DW),
        .READ_LATENCY (2)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .req_valid            (req_valid),
        .req_ready            (req_ready),
        .req_vs               (req_vs),
        .req_readSource       (req_readSource),
        .req_offset           (req_offset),
        .req_instructionIndex (req_instructionIndex),
        .vrf_valid            (vrf_valid),
        .vrf_ready            (vrf_ready),
        .vrf_vs               (vrf_vs),
        .vrf_readSource       (vrf_readSource),
        .vrf_offset           (vrf_offset),
        .vrf_instructionIndex (vrf_instructionIndex),
        .vrf_rdata            (vrf_rdata),
        .kill_valid           (kill_valid),
        .kill_index           (kill_index),
        .resp_valid           (resp_valid),
        .resp_data            (resp_data)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic         rst;
        logic [3:0]   v;
        logic         rdy;
        logic         kv;
        logic [2:0]   ki;
        logic [31:0]  rdata;
        logic [3:0]   e_rr;
        logic         e_vv;
        int           e_sel;
        logic [3:0]   e_resp;
    } vec_t;

    vec_t tbl[$];
    int   tests = 0;
    int   fails = 0;

    task automatic add(input logic rst, input logic [3:0] v, input logic rdy, input logic kv,
                       input logic [2:0] ki, input logic [31:0] rdata, input logic [3:0] e_rr,
                       input logic e_vv, input int e_sel, input logic [3:0] e_resp);
        vec_t t;
        t.rst = rst; t.v = v; t.rdy = rdy; t.kv = kv; t.ki = ki; t.rdata = rdata;
        t.e_rr = e_rr; t.e_vv = e_vv; t.e_sel = e_sel; t.e_resp = e_resp;
        tbl.push_back(t);
    endtask

    task automatic chk(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
        end
    endtask

    // Requester i carries vs=2i+1, readSource=i, offset=0x10+i, instructionIndex=i+1.
    initial begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_vs[i*5 +: 5]               = 5'(2*i + 1);
            req_readSource[i*2 +: 2]       = 2'(i);
            req_offset[i*8 +: 8]           = 8'(16 + i);
            req_instructionIndex[i*3 +: 3] = 3'(i + 1);
        end
    end

    initial begin
        logic [31:0] rd;
`ifdef VRF_READ_SCHED_PRIO0_EN
        add(1, 4'b0011, 1, 0, 0, 0, 4'b0000, 0, SEL_ZERO, 4'b0000);
        add(0, 4'b0011, 1, 0, 0, 0, 4'b0001, 0, SEL_ZERO, 4'b0000);
        add(0, 4'b0011, 1, 0, 0, 0, 4'b0001, 1, 0,        4'b0000);
        add(0, 4'b0011, 1, 0, 0, 0, 4'b0001, 1, 0,        4'b0000);
        add(0, 4'b1010, 1, 0, 0, 0, 4'b0010, 1, 0,        4'b0001);
        add(0, 4'b1010, 1, 0, 0, 0, 4'b1000, 1, 1,        4'b0001);
        add(0, 4'b1010, 1, 0, 0, 0, 4'b0010, 1, 3,        4'b0001);
        add(0, 4'b1010, 1, 0, 0, 0, 4'b1000, 1, 1,        4'b0010);
        add(0, 4'b0000, 1, 0, 0, 0, 4'b0000, 1, 3,        4'b1000);
`else
        // Reset, then round-robin 0,1,2,3 at full rate.
        add(1, 4'b1111, 1, 0, 0, 0, 4'b0000, 0, SEL_ZERO, 4'b0000);
        add(1, 4'b1111, 1, 0, 0, 0, 4'b0000, 0, SEL_ZERO, 4'b0000);
        add(0, 4'b1111, 1, 0, 0, 0, 4'b0001, 0, SEL_ZERO, 4'b0000);
        add(0, 4'b1111, 1, 0, 0, 0, 4'b0010, 1, 0,        4'b0000);
        add(0, 4'b1111, 1, 0, 0, 0, 4'b0100, 1, 1,        4'b0000);
        add(0, 4'b1111, 1, 0, 0, 0, 4'b1000, 1, 2,        4'b0001);
        // Three-cycle VRF stall, then same-cycle refill.
        add(0, 4'b1111, 0, 0, 0, 0, 4'b0000, 1, 3,        4'b0010);
        add(0, 4'b1111, 0, 0, 0, 0, 4'b0000, 1, 3,        4'b0100);
        add(0, 4'b1111, 0, 0, 0, 0, 4'b0000, 1, 3,        4'b0000);
        add(0, 4'b1111, 1, 0, 0, 0, 4'b0001, 1, 3,        4'b0000);
        // Kill of a stalled entry, then kill racing a fire.
        add(0, 4'b0100, 1, 0, 0, 0, 4'b0100, 1, 0,        4'b0000);
        add(0, 4'b0000, 0, 1, 3, 0, 4'b0000, 1, 2,        4'b1000);
        add(0, 4'b0000, 0, 0, 0, 0, 4'b0000, 0, SEL_SKIP, 4'b0001);
        add(0, 4'b0000, 1, 0, 0, 0, 4'b0000, 0, SEL_SKIP, 4'b0000);
        add(0, 4'b0100, 0, 0, 0, 0, 4'b0100, 0, SEL_SKIP, 4'b0000);
        add(0, 4'b0000, 1, 1, 3, 0, 4'b0000, 1, 2,        4'b0000);
        add(0, 4'b0000, 1, 0, 0, 0, 4'b0000, 0, SEL_SKIP, 4'b0000);
        add(0, 4'b0000, 1, 0, 0, 32'hDEADBEEF, 4'b0000, 0, SEL_SKIP, 4'b0100);
        add(0, 4'b0000, 1, 0, 0, 0, 4'b0000, 0, SEL_SKIP, 4'b0000);
        // Kill with a non-matching index leaves the entry alone.
        add(0, 4'b0001, 0, 0, 0, 0, 4'b0001, 0, SEL_SKIP, 4'b0000);
        add(0, 4'b0000, 0, 1, 3, 0, 4'b0000, 1, 0,        4'b0000);
        add(0, 4'b0000, 0, 0, 0, 0, 4'b0000, 1, 0,        4'b0000);
        // Two reads in flight, then reset discards them and rewinds the pointer.
        add(0, 4'b1111, 1, 0, 0, 0, 4'b0010, 1, 0,        4'b0000);
        add(0, 4'b1111, 1, 0, 0, 0, 4'b0100, 1, 1,        4'b0000);
        add(1, 4'b1111, 1, 0, 0, 0, 4'b0000, 0, SEL_ZERO, 4'b0000);
        add(0, 4'b1111, 0, 0, 0, 0, 4'b0001, 0, SEL_ZERO, 4'b0000);
        add(0, 4'b0000, 0, 0, 0, 0, 4'b0000, 1, 0,        4'b0000);
        add(0, 4'b0000, 0, 0, 0, 0, 4'b0000, 1, 0,        4'b0000);
`endif
        foreach (tbl[s]) begin
            @(posedge clock);
            #1;
            rd         = (tbl[s].rdata != 0) ? tbl[s].rdata : 32'hC0DE0000 + 32'(s);
            reset      = tbl[s].rst;
            req_valid  = tbl[s].v;
            vrf_ready  = tbl[s].rdy;
            kill_valid = tbl[s].kv;
            kill_index = tbl[s].ki;
            vrf_rdata  = rd;
            #1;
            chk("req_ready",  s, 32'(req_ready),  32'(tbl[s].e_rr));
            chk("vrf_valid",  s, 32'(vrf_valid),  32'(tbl[s].e_vv));
            chk("resp_valid", s, 32'(resp_valid), 32'(tbl[s].e_resp));
            chk("resp_data",  s, resp_data,       rd);
            if (tbl[s].e_sel == SEL_ZERO) begin
                chk("vrf_vs_rst",   s, 32'(vrf_vs),               32'd0);
                chk("vrf_src_rst",  s, 32'(vrf_readSource),       32'd0);
                chk("vrf_off_rst",  s, 32'(vrf_offset),           32'd0);
                chk("vrf_idx_rst",  s, 32'(vrf_instructionIndex), 32'd0);
            end else if (tbl[s].e_sel != SEL_SKIP) begin
                chk("vrf_vs",  s, 32'(vrf_vs),               32'(2*tbl[s].e_sel + 1));
                chk("vrf_src", s, 32'(vrf_readSource),       32'(tbl[s].e_sel % 4));
                chk("vrf_off", s, 32'(vrf_offset),           32'(16 + tbl[s].e_sel));
                chk("vrf_idx", s, 32'(vrf_instructionIndex), 32'(tbl[s].e_sel + 1));
            end
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
